intr_arb: RTL and testbench
===========================

# intr_arb

Unibus-style interrupt arbiter sitting between the iopage peripherals (line clock, serial ports, disk controllers) and the pdp11 CPU core. It collects level-sensitive interrupt requests, each with a vector and bus-request priority, and selects the highest-priority request above the current processor priority. It presents that request and its vector to the CPU and, when the CPU accepts it, returns a one-cycle acknowledge to the winning device. It is the consumer of each device's `interrupt` / `vector` / `interrupt_ack` triple.

## Interface

Parameters:
- `NUM_DEV`, default 4: number of requesting devices (1..8).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `dev_interrupt`  in  NUM_DEV  level request per device; a device holds it until it sees its ack.
- `dev_vector`  in  8*NUM_DEV  vector of device i on bits [8i+7:8i].
- `dev_ipl`  in  3*NUM_DEV  BR level of device i on bits [3i+2:3i] (normally 4..7).
- `cpu_ipl`  in  3  current processor priority (PSW[7:5]).
- `cpu_int_ack`  in  1  CPU accepts the presented interrupt.
- `cpu_int_req`  out  1  interrupt pending to CPU.
- `cpu_int_vector`  out  8  vector of the presented interrupt.
- `cpu_int_ipl`  out  3  BR level of the presented interrupt.
- `dev_interrupt_ack`  out  NUM_DEV  one-hot, one-cycle acknowledge to the winning device.

## Operation

- A device is eligible when `dev_interrupt[i]`=1 and `dev_ipl[i]` > `cpu_ipl` (unsigned, strict). A device at level 0 is never eligible.
- Winner: the eligible device with the highest `dev_ipl`. On a tie, the lowest index wins.
- State machine: IDLE, REQ, ACK, HOLD. All outputs are registered.
  - IDLE: if any device is eligible, latch the winner index, vector, and ipl, then go to REQ. Otherwise stay.
  - REQ: `cpu_int_req`=1, and the latched vector and ipl are driven stable.
    - If `cpu_int_ack`=1, go to ACK. The ack takes precedence over any withdraw condition in the same cycle.
    - Else, if the latched device has dropped `dev_interrupt`, or `cpu_ipl` >= the latched ipl, go to IDLE (withdraw).
    - No re-arbitration in REQ. A higher-priority request arriving during REQ waits until the next IDLE pass.
  - ACK: `cpu_int_req`=0 and `dev_interrupt_ack[winner]`=1 for exactly this cycle. Next state is HOLD.
  - HOLD: one dead cycle so the device's cleared request propagates. Next state is IDLE.
- `cpu_int_vector` and `cpu_int_ipl` hold their last latched value outside REQ. They are only meaningful while `cpu_int_req`=1.
- Reset (any time, including mid-REQ or mid-ACK) leaves the block as follows:
  - state IDLE;
  - `cpu_int_req`=0;
  - `cpu_int_vector`=0;
  - `cpu_int_ipl`=0;
  - `dev_interrupt_ack`=0;
  - latched index 0.
- The pending device is not acknowledged after a reset and keeps requesting.

## Timing

- Latency from request to CPU: eligible request sampled at edge N gives `cpu_int_req`=1 from edge N (IDLE→REQ on that edge).
- Acknowledge path: `cpu_int_ack` sampled high at edge M gives `cpu_int_req`=0 and `dev_interrupt_ack` high from edge M to edge M+1.
- HOLD covers M+1 to M+2, and the block is back in IDLE at M+2. The earliest next `cpu_int_req` is edge M+3.
- Device contract: a device clears its request on the edge where it samples its ack high. The arbiter must not re-grant the same request. HOLD guarantees this for registered devices.
- Withdraw: the condition sampled at edge W gives `cpu_int_req`=0 from W. Re-arbitration is possible at W+1.
- `cpu_int_ack` is ignored in IDLE, ACK and HOLD.

## Test plan

- Single device 0 (ipl 6, vector 0o100), `cpu_ipl`=0:
  - `cpu_int_req`=1 with vector 0o100 and ipl 6 one edge after the request;
  - `cpu_int_ack` held for one cycle;
  - `dev_interrupt_ack`=4'b0001 for exactly one cycle;
  - device drops its request, and no second request is presented.
- Priority and tie:
  - dev1 (ipl 4, vector 0o60) and dev2 (ipl 5, vector 0o64) requesting together → dev2 is presented first, then dev1 after its ack and HOLD;
  - dev0 and dev3 both at ipl 5 → dev0 wins.
- Masking: dev0 at ipl 6 with `cpu_ipl`=7 → no request. Lower `cpu_ipl` to 5 → `cpu_int_req` rises on the next edge.
- Withdraw:
  - in REQ, dev0 drops its request → `cpu_int_req` goes to 0 and no ack is issued;
  - in REQ, `cpu_ipl` is raised to 6 while the latched ipl is 6 → withdraw;
  - `cpu_int_ack` and the drop in the same cycle → ACK is taken and the ack pulse is issued.
- Reset asserted asynchronously mid-REQ and mid-ACK → all outputs go to 0 immediately with no ack pulse completed. After release, the still-held request is presented again.
- Back-to-back: dev0 re-asserts its request in the cycle immediately after its ack (line-clock style) → the second presentation starts no earlier than 3 edges after the `cpu_int_ack` sample.

Source files
------------

// File: rtl/intr_arb.sv
// -----------------------------------------------------------------------------
// intr_arb
//
// Interrupt arbiter between the iopage peripherals and the CPU core. Each
// device raises a level-sensitive request together with a vector and a
// bus-request (BR) level. The arbiter picks the highest-level request that is
// above the current processor priority and presents it to the CPU. When the
// CPU accepts it, the arbiter returns a one-cycle acknowledge to the winning
// device. A dead cycle follows every acknowledge so that a registered device
// has time to drop its request before the next arbitration pass.
//
// Ports
//   clk                in   system clock, rising-edge active
//   reset              in   asynchronous, active-high reset
//   dev_interrupt      in   [NUM_DEV]    level request per device
//   dev_vector         in   [8*NUM_DEV]  vector of device i on [8i+7:8i]
//   dev_ipl            in   [3*NUM_DEV]  BR level of device i on [3i+2:3i]
//   cpu_ipl            in   [3]          current processor priority
//   cpu_int_ack        in   1            CPU accepts the presented interrupt
//   cpu_int_req        out  1            interrupt pending to the CPU
//   cpu_int_vector     out  [8]          vector of the presented interrupt
//   cpu_int_ipl        out  [3]          BR level of the presented interrupt
//   dev_interrupt_ack  out  [NUM_DEV]    one-hot, one-cycle device acknowledge
// -----------------------------------------------------------------------------
module intr_arb #(
    parameter int NUM_DEV = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DEV-1:0]     dev_interrupt,
    input  logic [8*NUM_DEV-1:0]   dev_vector,
    input  logic [3*NUM_DEV-1:0]   dev_ipl,
    input  logic [2:0]             cpu_ipl,
    input  logic                   cpu_int_ack,
    output logic                   cpu_int_req,
    output logic [7:0]             cpu_int_vector,
    output logic [2:0]             cpu_int_ipl,
    output logic [NUM_DEV-1:0]     dev_interrupt_ack
);

    // Index width; a single-device build still gets a one-bit index.
    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;

    logic             any_elig_s;
    logic [IDX_W-1:0] win_idx_s;
    logic [7:0]       win_vec_s;
    logic [2:0]       win_ipl_s;
    logic             held_req_s;
    logic             withdraw_s;

    // One-hot decode of a device index.
    function automatic logic [NUM_DEV-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_DEV-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    // Winner selection: highest BR level strictly above cpu_ipl, lowest index on tie.
    // Seeding the running best with cpu_ipl folds the eligibility test into the
    // strict comparison, so level 0 can never win and equal levels keep the
    // earlier (lower) index.
    always_comb begin
        any_elig_s = 1'b0;
        win_idx_s  = '0;
        win_vec_s  = 8'h00;
        win_ipl_s  = cpu_ipl;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (dev_interrupt[i] && (dev_ipl[3*i +: 3] > win_ipl_s)) begin
                any_elig_s = 1'b1;
                win_idx_s  = IDX_W'(i);
                win_vec_s  = dev_vector[8*i +: 8];
                win_ipl_s  = dev_ipl[3*i +: 3];
            end else begin
                // not better than the current best; keep it
            end
        end
    end

    // Current request level of the latched device.
    always_comb begin
        held_req_s = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (idx_r == IDX_W'(i)) begin
                held_req_s = dev_interrupt[i];
            end else begin
                // other devices do not affect the presented request
            end
        end
    end

    // Withdraw when the presented device lets go or the CPU masks its level.
    assign withdraw_s = !held_req_s || (cpu_ipl >= cpu_int_ipl);

    // Arbitration state machine with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r           <= ST_IDLE;
            idx_r             <= '0;
            cpu_int_req       <= 1'b0;
            cpu_int_vector    <= 8'h00;
            cpu_int_ipl       <= 3'd0;
            dev_interrupt_ack <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    dev_interrupt_ack <= '0;
                    if (any_elig_s) begin
                        state_r        <= ST_REQ;
                        idx_r          <= win_idx_s;
                        cpu_int_vector <= win_vec_s;
                        cpu_int_ipl    <= win_ipl_s;
                        cpu_int_req    <= 1'b1;
                    end else begin
                        cpu_int_req    <= 1'b0;
                    end
                end

                ST_REQ: begin
                    // An accept in the same cycle as a withdraw condition wins.
                    if (cpu_int_ack) begin
                        state_r           <= ST_ACK;
                        cpu_int_req       <= 1'b0;
                        dev_interrupt_ack <= idx_onehot(idx_r);
                    end else if (withdraw_s) begin
                        state_r           <= ST_IDLE;
                        cpu_int_req       <= 1'b0;
                        dev_interrupt_ack <= '0;
                    end else begin
                        cpu_int_req       <= 1'b1;
                        dev_interrupt_ack <= '0;
                    end
                end

                ST_ACK: begin
                    state_r           <= ST_HOLD;
                    cpu_int_req       <= 1'b0;
                    dev_interrupt_ack <= '0;
                end

                ST_HOLD: begin
                    // Dead cycle: the device drops its request on the ack edge,
                    // so no arbitration happens here.
                    state_r           <= ST_IDLE;
                    cpu_int_req       <= 1'b0;
                    dev_interrupt_ack <= '0;
                end

                default: begin
                    state_r           <= ST_IDLE;
                    cpu_int_req       <= 1'b0;
                    dev_interrupt_ack <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_arb.sv
// -----------------------------------------------------------------------------
// tb_intr_arb
//
// Self-checking bench for intr_arb (NUM_DEV = 4). Directed steps walk the
// documented scenarios, then a randomized phase drives requests, levels,
// processor priority and accepts. Expected outputs come from a reference
// model that tracks the pending presentation and a post-accept blackout count.
// -----------------------------------------------------------------------------
module tb_intr_arb;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   dev_interrupt;
    logic [8*N-1:0] dev_vector;
    logic [3*N-1:0] dev_ipl;
    logic [2:0]     cpu_ipl;
    logic           cpu_int_ack;
    logic           cpu_int_req;
    logic [7:0]     cpu_int_vector;
    logic [2:0]     cpu_int_ipl;
    logic [N-1:0]   dev_interrupt_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic           m_req;
    logic [7:0]     m_vec;
    logic [2:0]     m_ipl;
    int             m_idx;
    int             m_blackout;
    logic [N-1:0]   m_ack;

    intr_arb #(.NUM_DEV(N)) dut (
        .clk               (clk),
        .reset             (reset),
        .dev_interrupt     (dev_interrupt),
        .dev_vector        (dev_vector),
        .dev_ipl           (dev_ipl),
        .cpu_ipl           (cpu_ipl),
        .cpu_int_ack       (cpu_int_ack),
        .cpu_int_req       (cpu_int_req),
        .cpu_int_vector    (cpu_int_vector),
        .cpu_int_ipl       (cpu_int_ipl),
        .dev_interrupt_ack (dev_interrupt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dev(input int i, input logic [2:0] lvl, input logic [7:0] vec);
        dev_ipl[3*i +: 3]    = lvl;
        dev_vector[8*i +: 8] = vec;
    endtask

    task automatic model_reset();
        m_req      = 1'b0;
        m_vec      = 8'h00;
        m_ipl      = 3'd0;
        m_idx      = 0;
        m_blackout = 0;
        m_ack      = '0;
    endtask

    function automatic logic eligible(input int i);
        return dev_interrupt[i] && (dev_ipl[3*i +: 3] > cpu_ipl);
    endfunction

    // Advance the model by one clock edge, using the inputs as they stand now.
    task automatic model_step();
        int top;
        int pick;
        if (reset) begin
            model_reset();
        end else begin
            m_ack = '0;
            if (m_req) begin
                if (cpu_int_ack) begin
                    m_req        = 1'b0;
                    m_ack[m_idx] = 1'b1;
                    m_blackout   = 2;   // the two edges after an accept grant nothing
                end else if (!dev_interrupt[m_idx] || (cpu_ipl >= m_ipl)) begin
                    m_req = 1'b0;
                end
            end else if (m_blackout > 0) begin
                m_blackout--;
            end else begin
                top = -1;
                for (int i = 0; i < N; i++)
                    if (eligible(i) && int'(dev_ipl[3*i +: 3]) > top)
                        top = int'(dev_ipl[3*i +: 3]);
                pick = -1;
                for (int i = 0; i < N; i++)
                    if (pick < 0 && eligible(i) && int'(dev_ipl[3*i +: 3]) == top)
                        pick = i;
                if (pick >= 0) begin
                    m_req = 1'b1;
                    m_idx = pick;
                    m_vec = dev_vector[8*pick +: 8];
                    m_ipl = dev_ipl[3*pick +: 3];
                end
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_req"}, 32'(cpu_int_req),       32'(m_req));
        check({tag, "_vec"}, 32'(cpu_int_vector),    32'(m_vec));
        check({tag, "_ipl"}, 32'(cpu_int_ipl),       32'(m_ipl));
        check({tag, "_ack"}, 32'(dev_interrupt_ack), 32'(m_ack));
    endtask

    // One clock: predict, let the edge happen, compare, then let registered
    // devices drop any request whose ack they have just sampled.
    task automatic cycle(input string tag);
        logic [N-1:0] ack_seen;
        ack_seen = m_ack;
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
        dev_interrupt = dev_interrupt & ~ack_seen;
    endtask

    task automatic accept(input string tag);
        cpu_int_ack = 1'b1;
        cycle(tag);
        cpu_int_ack = 1'b0;
        cycle(tag);
        cycle(tag);
    endtask

    initial begin
        int first_k;
        reset         = 1'b1;
        dev_interrupt = '0;
        dev_vector    = '0;
        dev_ipl       = '0;
        cpu_ipl       = 3'd0;
        cpu_int_ack   = 1'b0;
        model_reset();

        // reset state
        @(posedge clk);
        #1;
        check("rst_req", 32'(cpu_int_req),       32'd0);
        check("rst_vec", 32'(cpu_int_vector),    32'd0);
        check("rst_ipl", 32'(cpu_int_ipl),       32'd0);
        check("rst_ack", 32'(dev_interrupt_ack), 32'd0);
        reset = 1'b0;
        cycle("idle");

        // single device 0, level 6, vector 0o100
        set_dev(0, 3'd6, 8'o100);
        dev_interrupt = 4'b0001;
        cycle("single");
        check("single_req", 32'(cpu_int_req),    32'd1);
        check("single_vec", 32'(cpu_int_vector), 32'(8'o100));
        check("single_ipl", 32'(cpu_int_ipl),    32'd6);
        cpu_int_ack = 1'b1;
        cycle("single_acc");
        check("single_ackpulse", 32'(dev_interrupt_ack), 32'(4'b0001));
        cpu_int_ack = 1'b0;
        cycle("single_hold");
        check("single_ackone", 32'(dev_interrupt_ack), 32'd0);
        cycle("single_post");
        cycle("single_post");
        check("single_noreq", 32'(cpu_int_req), 32'd0);

        // priority: dev2 (level 5) before dev1 (level 4)
        set_dev(1, 3'd4, 8'o60);
        set_dev(2, 3'd5, 8'o64);
        dev_interrupt = 4'b0110;
        cycle("prio");
        check("prio_first", 32'(cpu_int_vector), 32'(8'o64));
        accept("prio_acc");
        cycle("prio_next");
        check("prio_second_req", 32'(cpu_int_req),    32'd1);
        check("prio_second",     32'(cpu_int_vector), 32'(8'o60));
        accept("prio_acc2");
        cycle("prio_idle");

        // tie at level 5: dev0 beats dev3
        set_dev(0, 3'd5, 8'o100);
        set_dev(3, 3'd5, 8'o70);
        dev_interrupt = 4'b1001;
        cycle("tie");
        check("tie_first", 32'(cpu_int_vector), 32'(8'o100));
        accept("tie_acc");
        cycle("tie_next");
        check("tie_second", 32'(cpu_int_vector), 32'(8'o70));
        accept("tie_acc2");
        cycle("tie_idle");

        // masking by cpu_ipl
        cpu_ipl = 3'd7;
        set_dev(0, 3'd6, 8'o100);
        dev_interrupt = 4'b0001;
        cycle("mask");
        cycle("mask");
        check("mask_noreq", 32'(cpu_int_req), 32'd0);
        cpu_ipl = 3'd5;
        cycle("unmask");
        check("unmask_req", 32'(cpu_int_req), 32'd1);
        accept("unmask_acc");
        cycle("unmask_idle");
        cpu_ipl = 3'd0;

        // withdraw by request drop
        dev_interrupt[0] = 1'b1;
        cycle("wd_drop");
        dev_interrupt[0] = 1'b0;
        cycle("wd_drop_w");
        check("wd_drop_req", 32'(cpu_int_req),       32'd0);
        check("wd_drop_ack", 32'(dev_interrupt_ack), 32'd0);
        cycle("wd_drop_after");
        check("wd_drop_ack2", 32'(dev_interrupt_ack), 32'd0);

        // withdraw by cpu_ipl reaching the latched level
        dev_interrupt[0] = 1'b1;
        cycle("wd_ipl");
        cpu_ipl = 3'd6;
        cycle("wd_ipl_w");
        check("wd_ipl_req", 32'(cpu_int_req), 32'd0);
        cycle("wd_ipl_hold");
        check("wd_ipl_req2", 32'(cpu_int_req), 32'd0);
        cpu_ipl = 3'd0;
        cycle("wd_ipl_rearb");
        check("wd_ipl_rearb_req", 32'(cpu_int_req), 32'd1);
        accept("wd_ipl_acc");
        cycle("wd_ipl_idle");

        // accept and drop in the same cycle: accept wins
        dev_interrupt[0] = 1'b1;
        cycle("ackdrop");
        dev_interrupt[0] = 1'b0;
        cpu_int_ack = 1'b1;
        cycle("ackdrop_acc");
        check("ackdrop_pulse", 32'(dev_interrupt_ack), 32'(4'b0001));
        cpu_int_ack = 1'b0;
        cycle("ackdrop_hold");
        cycle("ackdrop_idle");

        // asynchronous reset mid-REQ
        dev_interrupt[0] = 1'b1;
        cycle("rreq");
        check("rreq_req", 32'(cpu_int_req), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("rreq_async_req", 32'(cpu_int_req),    32'd0);
        check("rreq_async_vec", 32'(cpu_int_vector), 32'd0);
        check("rreq_async_ipl", 32'(cpu_int_ipl),    32'd0);
        model_reset();
        cycle("rreq_in");
        reset = 1'b0;
        cycle("rreq_out");
        check("rreq_again", 32'(cpu_int_req), 32'd1);

        // asynchronous reset mid-ACK
        cpu_int_ack = 1'b1;
        cycle("rack_acc");
        check("rack_pulse", 32'(dev_interrupt_ack), 32'(4'b0001));
        cpu_int_ack = 1'b0;
        #3 reset = 1'b1;
        #1;
        check("rack_async_ack", 32'(dev_interrupt_ack), 32'd0);
        check("rack_async_req", 32'(cpu_int_req),       32'd0);
        model_reset();
        cycle("rack_in");
        reset = 1'b0;
        cycle("rack_out");
        check("rack_again",     32'(cpu_int_req),    32'd1);
        check("rack_again_vec", 32'(cpu_int_vector), 32'(8'o100));
        accept("rack_acc2");
        cycle("rack_idle");

        // back-to-back: request re-raised right after the ack is seen
        dev_interrupt[0] = 1'b1;
        cycle("b2b");
        cpu_int_ack = 1'b1;
        cycle("b2b_acc");
        cpu_int_ack = 1'b0;
        first_k = -1;
        for (int k = 1; k <= 8; k++) begin
            cycle("b2b_wait");
            if (k == 1) dev_interrupt[0] = 1'b1;
            if (cpu_int_req && first_k < 0) first_k = k;
        end
        check("b2b_gap", 32'(first_k), 32'd3);
        accept("b2b_acc2");
        cycle("b2b_idle");

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!dev_interrupt[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        set_dev(i, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
                        dev_interrupt[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    dev_interrupt[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 7) == 0) cpu_ipl = 3'($urandom_range(0, 7));
            cpu_int_ack = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
